mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_W, default 32, width of addresses and data words.
REQ-002 Parameter STARVE_MAX, default 4, consecutive data grants tolerated while an instruction request waits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  asynchronous, active-low reset.
REQ-005 iREN  input  1  instruction-side read request (icache).
REQ-006 iaddr  input  WORD_W  instruction-side address.
REQ-007 iwait  output  1  high = instruction access not complete this cycle.
REQ-008 iload  output  WORD_W  instruction read data, valid when iREN & ~iwait.
REQ-009 dREN  input  1  data-side read request (dcache).
REQ-010 dWEN  input  1  data-side write request.
REQ-011 daddr  input  WORD_W  data-side address.
REQ-012 dstore  input  WORD_W  data-side write data.
REQ-013 dwait  output  1  high = data access not complete this cycle.
REQ-014 dload  output  WORD_W  data read data, valid when dREN & ~dwait.
REQ-015 ramREN  output  1  RAM read strobe.
REQ-016 ramWEN  output  1  RAM write strobe.
REQ-017 ramaddr  output  WORD_W  RAM address.
REQ-018 ramstore  output  WORD_W  RAM write data.
REQ-019 ramload  input  WORD_W  RAM read data.
REQ-020 ram_ready  input  1  RAM access completes this cycle.

Function
REQ-021 FSM states SHALL be IDLE, IGRANT, DGRANT; RAM outputs decoded combinationally from state.
REQ-022 IDLE: no RAM strobe, ramaddr/ramstore = 0, iwait = dwait = 1, iload = dload = 0.
REQ-023 IDLE -> DGRANT when (dREN|dWEN) and not the starvation case; IDLE -> IGRANT when iREN and either no data request or starvation case; else stay IDLE.
REQ-024 Starvation case: iREN & (dREN|dWEN) & starve_cnt == STARVE_MAX -> IGRANT.
REQ-025 DGRANT: ramaddr = daddr; dWEN -> ramWEN=1, ramstore=dstore, ramREN=0; else ramREN=1; dWEN takes precedence when dREN and dWEN both high.
REQ-026 DGRANT: dwait = ~ram_ready; dload = ramload when ram_ready & ~dWEN, else 0; iwait = 1.
REQ-027 IGRANT: ramREN=1, ramaddr=iaddr; iwait = ~ram_ready; iload = ramload when ram_ready, else 0; dwait = 1.
REQ-028 Grant state with ram_ready=1 -> IDLE next edge; ram_ready=0 -> hold grant.
REQ-029 Granted requester dropping its request (DGRANT with dREN=dWEN=0, IGRANT with iREN=0) -> IDLE next edge, RAM strobes low that cycle, wait stays 1.
REQ-030 Minimum per-access cost: 1 IDLE cycle + 1 grant cycle; no back-to-back grant without IDLE.
REQ-031 starve_cnt ($clog2(STARVE_MAX+1) bits): +1 on each completed DGRANT with iREN high, saturate at STARVE_MAX; clear on completed IGRANT or any cycle iREN=0.
REQ-032 Wait outputs SHALL only go low in the cycle the RAM completes; never both low same cycle.

Reset
REQ-033 nRST low SHALL asynchronously force state=IDLE, starve_cnt=0; outputs take IDLE values immediately (iwait=dwait=1, strobes 0, loads 0).
REQ-034 Reset during a grant SHALL abort the access; no completion reported to either side.

Verification
REQ-035 iREN only, iaddr=0x40, ram_ready at 2nd grant cycle, ramload=0x8C010004 -> ramREN=1/ramaddr=0x40 two cycles, iwait low one cycle, iload=0x8C010004.
REQ-036 iREN and dWEN same cycle, daddr=0x100, dstore=0xDEADBEEF, ram_ready=1 -> DGRANT first, ramWEN=1, ramstore=0xDEADBEEF; IGRANT follows after one IDLE cycle.
REQ-037 iREN held, dREN continuously reasserted, ram_ready=1 always -> exactly 4 data grants then 1 instruction grant, pattern repeats.
REQ-038 dREN & dWEN both high, daddr=0x200 -> ramWEN=1, ramREN=0, dload=0 on completion.
REQ-039 nRST pulsed low during DGRANT with ram_ready=0 -> ramREN/ramWEN drop same cycle, dwait=1, state IDLE after release, starve_cnt=0.
REQ-040 DGRANT, dREN dropped before ram_ready -> strobes low that cycle, IDLE next edge, dwait stays 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: data side wins by default, instruction
// side is forced in after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;

  logic dreq;
  logic starve;
  logic d_done;
  logic i_done;

  assign dreq   = dREN | dWEN;
  assign starve = iREN & dreq & (starve_cnt == SMAX);
  assign d_done = (state == DGRANT) & dreq & ram_ready;
  assign i_done = (state == IGRANT) & iREN & ram_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !starve)
            state <= DGRANT;
          else if (iREN)
            state <= IGRANT;
        end
        DGRANT: begin
          if (!dreq || ram_ready)
            state <= IDLE;
        end
        IGRANT: begin
          if (!iREN || ram_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // the count only means something while an instruction fetch waits
      if (!iREN || i_done)
        starve_cnt <= '0;
      else if (d_done && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      DGRANT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else if (dREN) begin
          ramREN = 1'b1;
        end
        dwait = ~d_done;
        if (d_done && !dWEN)
          dload = ramload;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~i_done;
        if (i_done)
          iload = ramload;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, write precedence,
// starvation rotation, request drop and reset abort.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // 2 = instruction grant, 1 = data read grant, 0 = no read strobe
  function automatic logic [31:0] gcode();
    if (ramREN && ramaddr == 32'h1000) return 32'd2;
    if (ramREN && ramaddr == 32'h2000) return 32'd1;
    return 32'd0;
  endfunction

  initial begin
    logic [31:0] exp;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ram_ready = 1'b0;
    #2;
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_ramren", ramREN, 0);
    check("rst_ramwen", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    iREN = 1'b1; dREN = 1'b1; ram_ready = 1'b1;
    tick;
    tick;
    check("rst_hold_ren", ramREN, 0);
    check("rst_hold_dwait", dwait, 1);
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
    nRST = 1'b1;
    tick;

    // instruction fetch, RAM ready on second grant cycle
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'h8C010004;
    settle;
    check("i_idle_ren", ramREN, 0);
    tick;
    check("i_ren1", ramREN, 1);
    check("i_addr1", ramaddr, 32'h40);
    check("i_wait1", iwait, 1);
    check("i_load1", iload, 0);
    tick;
    ram_ready = 1'b1;
    settle;
    check("i_ren2", ramREN, 1);
    check("i_addr2", ramaddr, 32'h40);
    check("i_wait2", iwait, 0);
    check("i_load2", iload, 32'h8C010004);
    check("i_dwait2", dwait, 1);
    tick;
    iREN = 1'b0; ram_ready = 1'b0;
    settle;
    check("i_after_ren", ramREN, 0);
    check("i_after_wait", iwait, 1);

    // simultaneous fetch and store: data first, then fetch
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1;
    daddr = 32'h100; dstore = 32'hDEADBEEF; ram_ready = 1'b1;
    ramload = 32'h11112222;
    settle;
    tick;
    check("w_wen", ramWEN, 1);
    check("w_ren", ramREN, 0);
    check("w_addr", ramaddr, 32'h100);
    check("w_store", ramstore, 32'hDEADBEEF);
    check("w_dwait", dwait, 0);
    check("w_iwait", iwait, 1);
    tick;
    dWEN = 1'b0;
    settle;
    check("w_gap_wen", ramWEN, 0);
    check("w_gap_ren", ramREN, 0);
    check("w_gap_iwait", iwait, 1);
    tick;
    check("w_i_ren", ramREN, 1);
    check("w_i_addr", ramaddr, 32'h44);
    check("w_i_wait", iwait, 0);
    check("w_i_load", iload, 32'h11112222);
    tick;
    iREN = 1'b0;

    // read and write together: write wins, no read data
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200;
    dstore = 32'hA5A5A5A5; ramload = 32'h12345678;
    settle;
    tick;
    check("rw_wen", ramWEN, 1);
    check("rw_ren", ramREN, 0);
    check("rw_addr", ramaddr, 32'h200);
    check("rw_dload", dload, 0);
    check("rw_dwait", dwait, 0);
    tick;
    dREN = 1'b0; dWEN = 1'b0;

    // plain data read
    dREN = 1'b1; daddr = 32'h300; ramload = 32'hCAFEF00D;
    settle;
    tick;
    check("dr_ren", ramREN, 1);
    check("dr_dload", dload, 32'hCAFEF00D);
    check("dr_dwait", dwait, 0);
    check("dr_iwait", iwait, 1);
    tick;
    dREN = 1'b0;

    // starvation rotation: D,-,D,-,D,-,D,-,I,- repeating
    iREN = 1'b1; dREN = 1'b1;
    iaddr = 32'h1000; daddr = 32'h2000; ram_ready = 1'b1;
    settle;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (k % 2 == 0) exp = 0;
      else exp = (((k - 1) / 2) % 5 == 4) ? 32'd2 : 32'd1;
      check("rot_grant", gcode(), exp);
      check("rot_waits", iwait | dwait, 1);
    end
    iREN = 1'b0; dREN = 1'b0;
    tick;

    // data request dropped before RAM completes
    dREN = 1'b1; daddr = 32'h400; ram_ready = 1'b0;
    settle;
    tick;
    check("drop_ren1", ramREN, 1);
    check("drop_dwait1", dwait, 1);
    dREN = 1'b0;
    settle;
    check("drop_ren2", ramREN, 0);
    check("drop_wen2", ramWEN, 0);
    check("drop_dwait2", dwait, 1);
    tick;
    dREN = 1'b1; ram_ready = 1'b1;
    settle;
    check("drop_idle_ren", ramREN, 0);
    tick;
    check("drop_regrant_ren", ramREN, 1);
    check("drop_regrant_dwait", dwait, 0);
    tick;
    dREN = 1'b0;

    // reset mid-grant with starve count at 3
    iREN = 1'b1; dREN = 1'b1;
    iaddr = 32'h1000; daddr = 32'h2000; ram_ready = 1'b1;
    settle;
    for (int k = 1; k <= 6; k++) begin
      tick;
      check("pre_rst_grant", gcode(), (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    ram_ready = 1'b0;
    tick;
    check("pre_rst_ren", ramREN, 1);
    check("pre_rst_dwait", dwait, 1);
    #2 nRST = 1'b0;
    #1;
    check("ar_ren", ramREN, 0);
    check("ar_wen", ramWEN, 0);
    check("ar_dwait", dwait, 1);
    check("ar_iwait", iwait, 1);
    check("ar_dload", dload, 0);
    #2 nRST = 1'b1;
    ram_ready = 1'b1;
    #1;
    check("ar_idle_ren", ramREN, 0);
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k % 2 == 0) exp = 0;
      else exp = (k == 9) ? 32'd2 : 32'd1;
      check("post_rst_grant", gcode(), exp);
    end
    iREN = 1'b0; dREN = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
